// File: rtl/rv32ima_pkg.sv
// rv32ima_pkg: shared definitions for the RV32IMA machine-mode CSR file.
//   - machine-mode CSR addresses
//   - Zicsr funct3 encodings (csr_funct3_t)
//   - mstatus field bit positions
//   - per-CSR reset values and WARL write masks, plus MISA_VAL
//   - warl_merge(): applies a write mask to an old/new value pair
package rv32ima_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // Zicsr funct3; 000 and 100 are reserved
    typedef enum logic [2:0] {
        F3_RSV0 = 3'b000,
        F3_RW   = 3'b001,
        F3_RS   = 3'b010,
        F3_RC   = 3'b011,
        F3_RSV4 = 3'b100,
        F3_RWI  = 3'b101,
        F3_RSI  = 3'b110,
        F3_RCI  = 3'b111
    } csr_funct3_t;

    // mstatus field positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    // Read-only identification
    localparam logic [31:0] MISA_VAL = 32'h4000_1101;  // RV32IMA

    // Reset values
    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;  // MPP = 11
    localparam logic [31:0] CSR_ZERO_RST = 32'h0000_0000;

    // WARL write masks
    localparam logic [31:0] MSTATUS_MASK      = 32'h0000_0088;  // MIE, MPIE
    localparam logic [31:0] MIE_MASK          = 32'h0000_0888;  // MSIE, MTIE, MEIE
    localparam logic [31:0] MTVEC_MASK_DIRECT = 32'hFFFF_FFFC;
    localparam logic [31:0] MTVEC_MASK_VEC    = 32'hFFFF_FFFD;
    localparam logic [31:0] MEPC_MASK         = 32'hFFFF_FFFC;
    localparam logic [31:0] FULL_MASK         = 32'hFFFF_FFFF;

    function automatic logic [31:0] warl_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/csr_file_m_counter.sv
// csr_counter64: free-running counter exposed as two XLEN-wide CSR halves.
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   i_inc      : add one this cycle (full-width add, carry crosses halves)
//   i_wr_lo    : load low half from i_wdata; high half holds, no increment
//   i_wr_hi    : load high half from i_wdata; low half holds, no increment
//   i_wdata    : CSR write data
//   o_count    : current count
module csr_counter64 #(
    parameter int CNT_W = 64,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_wr_lo,
    input  logic             i_wr_hi,
    input  logic [XLEN-1:0]  i_wdata,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // A software write to either half takes precedence over the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_wr_lo) begin
            r_count[XLEN-1:0] <= i_wdata;
        end else if (i_wr_hi) begin
            r_count[CNT_W-1:XLEN] <= i_wdata;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file (Zicsr ops, trap entry, MRET, counters).
//   clk, rst          : clock, asynchronous active-high reset
//   csr_valid ..      : CSR instruction inputs (funct3, addr, rs1, zimm,
//                       rs1/zimm-is-zero flag)
//   csr_rdata         : pre-write CSR value, combinational (0 when illegal)
//   csr_illegal       : illegal access, combinational
//   instret_inc       : one instruction retired this cycle
//   trap_valid ..     : trap entry with cause, pc and tval
//   mret_valid        : MRET executing
//   trap_target       : trap handler PC (direct or vectored)
//   mepc_out          : current mepc (MRET return target)
//   mstatus_mie       : global interrupt enable
// csr_valid is a single-cycle qualifier with no backpressure: an access is
// performed in every cycle it is high, and ignored in every cycle it is low.
module csr_file_m
    import rv32ima_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int HART_ID     = 0,
    parameter int CNT_W       = 64,
    parameter int VECTORED_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [2:0]      csr_funct3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_rs1,
    input  logic [4:0]      csr_uimm,
    input  logic            csr_rs1_idx_zero,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            instret_inc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    output logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] mepc_out,
    output logic            mstatus_mie
);

    localparam logic [31:0] L_MTVEC_MASK =
        (VECTORED_EN != 0) ? MTVEC_MASK_VEC : MTVEC_MASK_DIRECT;

    logic             r_mstatus_mie;
    logic             r_mstatus_mpie;
    logic [XLEN-1:0]  r_mie;
    logic [XLEN-1:0]  r_mtvec;
    logic [XLEN-1:0]  r_mscratch;
    logic [XLEN-1:0]  r_mepc;
    logic [XLEN-1:0]  r_mcause;
    logic [XLEN-1:0]  r_mtval;

    logic [CNT_W-1:0] w_mcycle;
    logic [CNT_W-1:0] w_minstret;

    csr_funct3_t      w_f3;
    logic             w_hit;
    logic             w_rsv_f3;
    logic             w_wr_req;
    logic             w_illegal;
    logic             w_wen;
    logic [XLEN-1:0]  w_mstatus;
    logic [XLEN-1:0]  w_rval;
    logic [XLEN-1:0]  w_wsrc;
    logic [XLEN-1:0]  w_wval;
    logic [XLEN-1:0]  w_tvec_base;
    logic             w_unused;

    // mstatus is stored as two bits; MPP is hardwired to machine mode.
    always_comb begin
        w_mstatus                   = MSTATUS_RST;
        w_mstatus[MSTATUS_MIE_BIT]  = r_mstatus_mie;
        w_mstatus[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
    end

    // Read mux; w_hit drops for unimplemented addresses.
    always_comb begin
        w_hit  = 1'b1;
        w_rval = '0;
        case (csr_addr)
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: w_rval = '0;
            CSR_MHARTID:   w_rval = XLEN'(HART_ID);
            CSR_MISA:      w_rval = MISA_VAL;
            CSR_MSTATUS:   w_rval = w_mstatus;
            CSR_MIE:       w_rval = r_mie;
            CSR_MIP:       w_rval = '0;  // no pending-interrupt sources wired in
            CSR_MTVEC:     w_rval = r_mtvec;
            CSR_MSCRATCH:  w_rval = r_mscratch;
            CSR_MEPC:      w_rval = r_mepc;
            CSR_MCAUSE:    w_rval = r_mcause;
            CSR_MTVAL:     w_rval = r_mtval;
            CSR_MCYCLE:    w_rval = w_mcycle[XLEN-1:0];
            CSR_MCYCLEH:   w_rval = w_mcycle[CNT_W-1:XLEN];
            CSR_MINSTRET:  w_rval = w_minstret[XLEN-1:0];
            CSR_MINSTRETH: w_rval = w_minstret[CNT_W-1:XLEN];
            default:       w_hit  = 1'b0;
        endcase
    end

    // Operation decode and write-value computation.
    always_comb begin
        w_f3     = csr_funct3_t'(csr_funct3);
        w_wsrc   = csr_funct3[2] ? {{(XLEN-5){1'b0}}, csr_uimm} : csr_rs1;
        w_wval   = w_rval;
        w_wr_req = 1'b0;
        w_rsv_f3 = 1'b0;
        case (w_f3)
            F3_RW, F3_RWI: begin
                w_wval   = w_wsrc;
                w_wr_req = 1'b1;
            end
            F3_RS, F3_RSI: begin
                w_wval   = w_rval | w_wsrc;
                w_wr_req = !csr_rs1_idx_zero;
            end
            F3_RC, F3_RCI: begin
                w_wval   = w_rval & ~w_wsrc;
                w_wr_req = !csr_rs1_idx_zero;
            end
            default: w_rsv_f3 = 1'b1;
        endcase
    end

    // addr[11:10] == 11 is the read-only CSR space.
    assign w_illegal = csr_valid &&
                       (!w_hit || w_rsv_f3 || (w_wr_req && (csr_addr[11:10] == 2'b11)));
    // A trap in the same cycle cancels the CSR write completely.
    assign w_wen     = csr_valid && !w_illegal && w_wr_req && !trap_valid;

    assign csr_illegal = w_illegal;
    assign csr_rdata   = (csr_valid && !w_illegal) ? w_rval : '0;

    // Trap > MRET > CSR write. MRET only competes with a write to mstatus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus_mie  <= MSTATUS_RST[MSTATUS_MIE_BIT];
            r_mstatus_mpie <= MSTATUS_RST[MSTATUS_MPIE_BIT];
            r_mie          <= CSR_ZERO_RST;
            r_mtvec        <= CSR_ZERO_RST;
            r_mscratch     <= CSR_ZERO_RST;
            r_mepc         <= CSR_ZERO_RST;
            r_mcause       <= CSR_ZERO_RST;
            r_mtval        <= CSR_ZERO_RST;
        end else if (trap_valid) begin
            r_mepc         <= {trap_pc[XLEN-1:2], 2'b00};
            r_mcause       <= trap_cause;
            r_mtval        <= trap_tval;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else begin
            if (mret_valid) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_wen && (csr_addr == CSR_MSTATUS)) begin
                r_mstatus_mie  <= w_wval[MSTATUS_MIE_BIT];
                r_mstatus_mpie <= w_wval[MSTATUS_MPIE_BIT];
            end
            if (w_wen) begin
                case (csr_addr)
                    CSR_MIE:      r_mie      <= warl_merge(r_mie, w_wval, MIE_MASK);
                    CSR_MTVEC:    r_mtvec    <= warl_merge(r_mtvec, w_wval, L_MTVEC_MASK);
                    CSR_MSCRATCH: r_mscratch <= warl_merge(r_mscratch, w_wval, FULL_MASK);
                    CSR_MEPC:     r_mepc     <= warl_merge(r_mepc, w_wval, MEPC_MASK);
                    CSR_MCAUSE:   r_mcause   <= warl_merge(r_mcause, w_wval, FULL_MASK);
                    CSR_MTVAL:    r_mtval    <= warl_merge(r_mtval, w_wval, FULL_MASK);
                    default: ;
                endcase
            end
        end
    end

    csr_counter64 #(
        .CNT_W (CNT_W),
        .XLEN  (XLEN)
    ) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (1'b1),
        .i_wr_lo (w_wen && (csr_addr == CSR_MCYCLE)),
        .i_wr_hi (w_wen && (csr_addr == CSR_MCYCLEH)),
        .i_wdata (w_wval),
        .o_count (w_mcycle)
    );

    csr_counter64 #(
        .CNT_W (CNT_W),
        .XLEN  (XLEN)
    ) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (instret_inc),
        .i_wr_lo (w_wen && (csr_addr == CSR_MINSTRET)),
        .i_wr_hi (w_wen && (csr_addr == CSR_MINSTRETH)),
        .i_wdata (w_wval),
        .o_count (w_minstret)
    );

    // Vectored mode applies to interrupts only; exceptions use the base.
    assign w_tvec_base = {r_mtvec[XLEN-1:2], 2'b00};
    assign trap_target = (r_mtvec[0] && trap_cause[XLEN-1])
                       ? w_tvec_base + {{(XLEN-7){1'b0}}, trap_cause[4:0], 2'b00}
                       : w_tvec_base;

    assign mepc_out    = r_mepc;
    assign mstatus_mie = r_mstatus_mie;

    // mepc is word aligned, so the low pc bits are never stored.
    assign w_unused = &{1'b0, trap_pc[1:0]};

endmodule
